aes_load_ctrl_wddl: RTL and testbench

AES_LOAD_CTRL_WDDL -- requirements
Module: aes_load_ctrl_wddl

---
 rtl/aes_load_ctrl_wddl_if.sv | 30 +++
 rtl/aes_load_ctrl_wddl.sv | 103 ++++++++++
 tb/tb_aes_load_ctrl_wddl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/aes_load_ctrl_wddl_if.sv
`default_nettype none
// ============================================================================
// Module      : aes_load_ctrl_wddl_if
// Description : Load/round-control bus between the AES controller and its
//               datapath; dual-rail text and round constant.
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_load_ctrl_wddl_if;
    logic         ld;
    logic [127:0] text_in;
    logic [127:0] text_in_r;
    logic [127:0] text_in_r_n;
    logic         ld_r;
    logic [3:0]   round;
    logic [7:0]   rcon;
    logic [7:0]   rcon_n;
    logic         busy;
    logic         done;

    modport master (
        output ld, text_in,
        input  text_in_r, text_in_r_n, ld_r, round, rcon, rcon_n, busy, done
    );

    modport slave (
        input  ld, text_in,
        output text_in_r, text_in_r_n, ld_r, round, rcon, rcon_n, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/aes_load_ctrl_wddl.sv
`default_nettype none
// ============================================================================
// Module      : aes_load_ctrl_wddl
// Description : AES plaintext load and round sequencer with dual-rail
//               (true/false) registered text and round-constant outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_load_ctrl_wddl (
    input wire                  clk,
    input wire                  rst,
    aes_load_ctrl_wddl_if.slave bus
);
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_load  = 2'd1;
    localparam logic [1:0] c_st_round = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [1:0]   r_state;
    logic [3:0]   r_dcnt;
    logic [127:0] r_text_in_r;
    logic [127:0] r_text_in_r_n;
    logic         r_ld_r;
    logic [3:0]   r_round;
    logic [7:0]   r_rcon;
    logic [7:0]   r_rcon_n;
    logic         r_busy;
    logic         r_done;

    logic [3:0]   w_dcnt_nxt;
    logic [7:0]   w_rcon_nxt;

    // Round 10 carries no constant, so the doubling chain is cut to zero there.
    always_comb begin
        w_dcnt_nxt = (r_dcnt != 4'd0) ? (r_dcnt - 4'd1) : 4'd0;
        if (w_dcnt_nxt == 4'd1)
            w_rcon_nxt = 8'h00;
        else if (r_rcon == 8'h80)
            w_rcon_nxt = 8'h1b;
        else
            w_rcon_nxt = {r_rcon[6:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= c_st_idle;
            r_dcnt        <= 4'd0;
            r_text_in_r   <= '0;
            r_text_in_r_n <= '1;
            r_ld_r        <= 1'b0;
            r_round       <= 4'd0;
            r_rcon        <= 8'h00;
            r_rcon_n      <= 8'hff;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_ld_r <= 1'b0;
            r_done <= 1'b0;
            if (bus.ld) begin
                // A new request always wins, aborting whatever was in flight.
                r_state       <= c_st_load;
                r_dcnt        <= 4'd11;
                r_text_in_r   <= bus.text_in;
                r_text_in_r_n <= ~bus.text_in;
                r_ld_r        <= 1'b1;
                r_round       <= 4'd0;
                r_rcon        <= 8'h01;
                r_rcon_n      <= 8'hfe;
                r_busy        <= 1'b1;
            end else begin
                case (r_state)
                    c_st_load, c_st_round: begin
                        r_dcnt <= w_dcnt_nxt;
                        if (r_state == c_st_round && r_dcnt == 4'd1) begin
                            r_state <= c_st_done;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state  <= c_st_round;
                            r_round  <= 4'd11 - w_dcnt_nxt;
                            r_rcon   <= w_rcon_nxt;
                            r_rcon_n <= ~w_rcon_nxt;
                            r_busy   <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= c_st_idle;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.text_in_r   = r_text_in_r;
    assign bus.text_in_r_n = r_text_in_r_n;
    assign bus.ld_r        = r_ld_r;
    assign bus.round       = r_round;
    assign bus.rcon        = r_rcon;
    assign bus.rcon_n      = r_rcon_n;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
endmodule
`default_nettype wire

// File: tb/tb_aes_load_ctrl_wddl.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_load_ctrl_wddl
// Description : Directed self-checking bench for aes_load_ctrl_wddl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_load_ctrl_wddl;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic rail_en;

    aes_load_ctrl_wddl_if bus ();

    aes_load_ctrl_wddl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] c_pat_a  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_pat_an = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] c_ones   = {128{1'b1}};
    localparam logic [127:0] c_pat_b  = 128'h0123456789abcdef0f1e2d3c4b5a6978;
    localparam logic [127:0] c_pat_c  = 128'hdeadbeefcafef00d5555aaaa12345678;

    logic [7:0] rcon_tbl [0:10];
    initial begin
        rcon_tbl[0] = 8'h01; rcon_tbl[1] = 8'h02; rcon_tbl[2]  = 8'h04;
        rcon_tbl[3] = 8'h08; rcon_tbl[4] = 8'h10; rcon_tbl[5]  = 8'h20;
        rcon_tbl[6] = 8'h40; rcon_tbl[7] = 8'h80; rcon_tbl[8]  = 8'h1b;
        rcon_tbl[9] = 8'h36; rcon_tbl[10] = 8'h00;
    end

    // Dual-rail complement checked every cycle once reset has been applied.
    always @(negedge clk) begin
        if (rail_en) begin
            checks = checks + 1;
            if ((bus.text_in_r ^ bus.text_in_r_n) !== c_ones ||
                (bus.rcon ^ bus.rcon_n) !== 8'hff) begin
                failures = failures + 1;
                $display("FAIL rail_invariant: text_r=%h text_r_n=%h rcon=%h rcon_n=%h",
                         bus.text_in_r, bus.text_in_r_n, bus.rcon, bus.rcon_n);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.ld = 1'b1;
        bus.text_in = c_pat_c;
        tick();
        rail_en = 1'b1;
        tick();
        checks = checks + 1;
        if ({bus.text_in_r, bus.text_in_r_n, bus.ld_r, bus.round, bus.rcon,
             bus.rcon_n, bus.busy, bus.done} !==
            {128'h0, c_ones, 1'b0, 4'd0, 8'h00, 8'hff, 1'b0, 1'b0}) begin
            failures = failures + 1;
            $display("FAIL reset_values: text_r=%h ld_r=%b round=%0d rcon=%h busy=%b done=%b required zeros",
                     bus.text_in_r, bus.ld_r, bus.round, bus.rcon, bus.busy, bus.done);
        end
        bus.ld = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        bus.ld = 1'b1;
        bus.text_in = c_pat_a;
        tick();
        bus.ld = 1'b0;
        bus.text_in = c_pat_b;
        checks = checks + 1;
        if (bus.ld_r !== 1'b1 || bus.text_in_r !== c_pat_a ||
            bus.text_in_r_n !== c_pat_an || bus.busy !== 1'b1) begin
            failures = failures + 1;
            $display("FAIL basic_load: ld_r=%b text_r=%h text_r_n=%h busy=%b required 1 %h %h 1",
                     bus.ld_r, bus.text_in_r, bus.text_in_r_n, bus.busy, c_pat_a, c_pat_an);
        end
        for (int i = 0; i <= 10; i++) begin
            if (i > 0) tick();
            checks = checks + 1;
            if (bus.round !== i[3:0] || bus.rcon !== rcon_tbl[i] || bus.done !== 1'b0 ||
                bus.busy !== 1'b1 || (i > 0 && bus.ld_r !== 1'b0)) begin
                failures = failures + 1;
                $display("FAIL basic_round%0d: round=%0d rcon=%h done=%b busy=%b ld_r=%b required round=%0d rcon=%h done=0 busy=1",
                         i, bus.round, bus.rcon, bus.done, bus.busy, bus.ld_r, i, rcon_tbl[i]);
            end
        end
        tick();
        checks = checks + 1;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.round !== 4'd10) begin
            failures = failures + 1;
            $display("FAIL basic_done: done=%b busy=%b round=%0d required 1 0 10",
                     bus.done, bus.busy, bus.round);
        end
        tick();
        checks = checks + 1;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.round !== 4'd10 ||
            bus.rcon !== 8'h00 || bus.text_in_r !== c_pat_a || bus.ld_r !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL basic_idle: done=%b busy=%b round=%0d rcon=%h text_r=%h required 0 0 10 00 %h",
                     bus.done, bus.busy, bus.round, bus.rcon, bus.text_in_r, c_pat_a);
        end
    endtask

    task automatic test_restart();
        bus.ld = 1'b1;
        bus.text_in = c_pat_a;
        tick();
        bus.ld = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        bus.ld = 1'b1;
        bus.text_in = c_ones;
        tick();
        bus.ld = 1'b0;
        checks = checks + 1;
        if (bus.ld_r !== 1'b1 || bus.round !== 4'd0 || bus.text_in_r !== c_ones ||
            bus.text_in_r_n !== 128'h0 || bus.rcon !== 8'h01) begin
            failures = failures + 1;
            $display("FAIL restart_load: ld_r=%b round=%0d rcon=%h text_r=%h text_r_n=%h required 1 0 01 ones zeros",
                     bus.ld_r, bus.round, bus.rcon, bus.text_in_r, bus.text_in_r_n);
        end
        for (int i = 1; i <= 11; i++) begin
            tick();
            checks = checks + 1;
            if (bus.done !== (i == 11)) begin
                failures = failures + 1;
                $display("FAIL restart_done_t%0d: done=%b required %b", i + 6, bus.done, (i == 11));
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic saw_done;
        bus.ld = 1'b1;
        bus.text_in = c_pat_b;
        tick();
        bus.ld = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks = checks + 1;
        if ({bus.text_in_r, bus.text_in_r_n, bus.ld_r, bus.round, bus.rcon,
             bus.rcon_n, bus.busy, bus.done} !==
            {128'h0, c_ones, 1'b0, 4'd0, 8'h00, 8'hff, 1'b0, 1'b0}) begin
            failures = failures + 1;
            $display("FAIL midreset_values: text_r=%h ld_r=%b round=%0d rcon=%h busy=%b done=%b required zeros",
                     bus.text_in_r, bus.ld_r, bus.round, bus.rcon, bus.busy, bus.done);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
        end
        checks = checks + 1;
        if (saw_done !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL midreset_no_done: activity=%b required 0", saw_done);
        end
        bus.ld = 1'b1;
        bus.text_in = c_pat_c;
        tick();
        bus.ld = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            tick();
            checks = checks + 1;
            if (bus.done !== (i == 11)) begin
                failures = failures + 1;
                $display("FAIL midreset_rerun_t%0d: done=%b required %b", i + 1, bus.done, (i == 11));
            end
        end
        tick();
    endtask

    task automatic test_held_ld();
        logic [127:0] pats [0:2];
        pats[0] = c_pat_a;
        pats[1] = c_pat_b;
        pats[2] = c_pat_c;
        for (int i = 0; i < 3; i++) begin
            bus.ld = 1'b1;
            bus.text_in = pats[i];
            tick();
            checks = checks + 1;
            if (bus.ld_r !== 1'b1 || bus.text_in_r !== pats[i] || bus.round !== 4'd0 ||
                bus.busy !== 1'b1) begin
                failures = failures + 1;
                $display("FAIL held_cycle%0d: ld_r=%b text_r=%h round=%0d busy=%b required 1 %h 0 1",
                         i, bus.ld_r, bus.text_in_r, bus.round, bus.busy, pats[i]);
            end
        end
        bus.ld = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            tick();
            checks = checks + 1;
            if (bus.done !== (i == 11) || bus.ld_r !== 1'b0) begin
                failures = failures + 1;
                $display("FAIL held_done_t%0d: done=%b ld_r=%b required done=%b ld_r=0",
                         i + 1, bus.done, bus.ld_r, (i == 11));
            end
        end
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rail_en  = 1'b0;
        rst      = 1'b0;
        bus.ld   = 1'b0;
        bus.text_in = '0;
        test_reset();
        test_basic();
        test_restart();
        test_reset_mid();
        test_held_ld();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
